dist_bin2bcd: RTL and testbench

DIST_BIN2BCD -- requirements
Module: dist_bin2bcd

---
 rtl/dist_bin2bcd_pkg.sv | 21 ++
 rtl/dist_bin2bcd_adj.sv | 12 +
 rtl/dist_bin2bcd.sv | 117 +++++++++++
 tb/tb_dist_bin2bcd.sv | 137 +++++++++++++
 4 files changed

// File: rtl/dist_bin2bcd_pkg.sv
// Shared types and constants for the 16-bit binary to 4-digit BCD converter.
package dist_bin2bcd_pkg;

  localparam int BIN_W      = 16;
  localparam int BCD_DIGITS = 4;
  localparam int ITER_N     = 16;
  localparam int DEC_MAX    = 9999;
  localparam int CNT_W      = 5;
  localparam int BCD_W      = BCD_DIGITS * 4;
  localparam int ACC_W      = (BCD_DIGITS + 1) * 4;

  // Packed BCD image of DEC_MAX, driven out on saturation.
  localparam logic [BCD_W-1:0] BCD_SAT = 16'h9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/dist_bin2bcd_adj.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_comb begin
    q = d;
    if (d >= 4'd5) q = d + 4'd3;
  end

endmodule

// File: rtl/dist_bin2bcd.sv
// Iterative shift-add-3 binary to BCD converter, one bit per clock.
// Define BCD_SAT_EN to saturate inputs above 9999 to 9999 and flag ovf.
module dist_bin2bcd
  import dist_bin2bcd_pkg::*;
(
  input  logic             CLK_50M,
  input  logic             RST,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             bin_valid,
  output logic             busy,
  output logic [BCD_W-1:0] bcd_out,
  output logic             bcd_valid,
  output logic             ovf
);

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   acc_adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               vld_q, vld_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;

  for (genvar i = 0; i < BCD_DIGITS + 1; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (acc_q[i*4 +: 4]),
      .q (acc_adj[i*4 +: 4])
    );
  end

`ifdef BCD_SAT_EN
  logic ovf_q, ovf_d;
  logic acc_ovf;

  // A nonzero fifth digit means the value exceeded four digits.
  assign acc_ovf = acc_q[ACC_W-1 -: 4] != 4'd0;
`endif

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    vld_d   = 1'b0;
    bcd_d   = bcd_q;
`ifdef BCD_SAT_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bin_valid) begin
          bin_d   = bin_in;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = ACC_W'({acc_adj, bin_q[BIN_W-1]});
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER_N - 1)) state_d = DONE;
      end
      DONE: begin
`ifdef BCD_SAT_EN
        ovf_d = acc_ovf;
        bcd_d = acc_ovf ? BCD_SAT : acc_q[BCD_W-1:0];
`else
        bcd_d = acc_q[BCD_W-1:0];
`endif
        vld_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_50M or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      vld_q   <= vld_d;
      bcd_q   <= bcd_d;
    end
  end

`ifdef BCD_SAT_EN
  always_ff @(posedge CLK_50M or negedge RST) begin
    if (!RST) ovf_q <= 1'b0;
    else      ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy      = busy_q;
  assign bcd_valid = vld_q;
  assign bcd_out   = bcd_q;

endmodule

// File: tb/tb_dist_bin2bcd.sv
// Directed bench for dist_bin2bcd with a scoreboard of expected results.
// Honours BCD_SAT_EN in its reference model.
module tb_dist_bin2bcd;

  logic        CLK_50M = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] bin_in = '0;
  logic        bin_valid = 1'b0;
  logic        busy;
  logic [15:0] bcd_out;
  logic        bcd_valid;
  logic        ovf;

  int n_pass = 0;
  int n_tot  = 0;
  logic [16:0] exp_q[$];

  dist_bin2bcd dut (
    .CLK_50M   (CLK_50M),
    .RST       (RST),
    .bin_in    (bin_in),
    .bin_valid (bin_valid),
    .busy      (busy),
    .bcd_out   (bcd_out),
    .bcd_valid (bcd_valid),
    .ovf       (ovf)
  );

  always #5 CLK_50M = ~CLK_50M;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [16:0] model(input int v);
    int m;
`ifdef BCD_SAT_EN
    if (v > 9999) return {1'b1, 16'h9999};
`endif
    m = v % 10000;
    return {1'b0, 4'(m / 1000), 4'((m / 100) % 10),
            4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  always @(negedge CLK_50M) begin
    if (bcd_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 32'(bcd_out), 32'hFFFF_FFFF);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        chk("bcd_out", 32'(bcd_out), 32'(e[15:0]));
        chk("ovf", 32'(ovf), 32'(e[16]));
      end
    end
  end

  // Called just after a rising edge; the next edge is acceptance edge k.
  // ign_at > 0 re-asserts bin_valid with 777 at edge k+ign_at.
  task automatic convert(input int v, input int ign_at);
    int n;
    bin_in    = 16'(v);
    bin_valid = 1'b1;
    exp_q.push_back(model(v));
    @(posedge CLK_50M); #1;
    bin_valid = 1'b0;
    chk("busy_accept", 32'(busy), 32'd1);
    chk("valid_clear", 32'(bcd_valid), 32'd0);
    n = 0;
    while (!bcd_valid && n < 40) begin
      if (n + 1 == ign_at) begin
        bin_in    = 16'd777;
        bin_valid = 1'b1;
      end
      @(posedge CLK_50M); #1;
      bin_valid = 1'b0;
      n++;
    end
    chk("latency", 32'(n), 32'd17);
    chk("busy_done", 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge CLK_50M);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(bcd_valid), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    RST = 1'b1;
    @(posedge CLK_50M); #1;

    convert(1234, 0);
    convert(0, 0);
    convert(9999, 0);
    convert(12345, 0);
    convert(65535, 0);
    convert(42, 5);
    repeat (25) @(posedge CLK_50M);
    #1;
    chk("ignored_busy", 32'(busy), 32'd0);
    chk("ignored_bcd", 32'(bcd_out), 32'h0042);

    // Abort a conversion of 5000 partway through with reset.
    bin_in    = 16'd5000;
    bin_valid = 1'b1;
    @(posedge CLK_50M); #1;
    bin_valid = 1'b0;
    repeat (8) @(posedge CLK_50M);
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    RST = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(bcd_valid), 32'd0);
    chk("abort_bcd", 32'(bcd_out), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    repeat (20) @(posedge CLK_50M);
    #1;
    RST = 1'b1;
    @(posedge CLK_50M); #1;

    convert(42, 0);
    convert(100, 0);
    convert(200, 0);
    repeat (5) @(posedge CLK_50M);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
